fft8_bf_sched: RTL and testbench



---
 rtl/fft8_pkg.sv | 32 +++
 rtl/fft8_bf_sched_if.sv | 38 +++
 rtl/fft8_tag_pipe.sv | 32 +++
 rtl/fft8_bf_sched.sv | 117 +++++++++++
 tb/tb_fft8_bf_sched.sv | 119 +++++++++++
 5 files changed

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants, FSM state type and butterfly tag for the 8-point FFT scheduler
package fft8_pkg;
   localparam int N_PTS    = 8;
   localparam int N_STAGES = 3;
   localparam int ADDR_W   = 3;
   localparam int TW_W     = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr_a;
      logic [ADDR_W-1:0] addr_b;
   } bf_tag_t;

   function automatic bf_tag_t bf_addr(input logic [1:0] s, input logic [1:0] k);
      logic [2:0] span, pos;
      bf_tag_t t;
      span     = 3'd1 << s;
      pos      = {1'b0, k} & (span - 3'd1);
      t.valid  = 1'b1;
      t.addr_a = (({1'b0, k} >> s) << (s + 2'd1)) | pos;
      t.addr_b = t.addr_a + span;
      return t;
   endfunction

   function automatic logic [TW_W-1:0] bf_tw(input logic [1:0] s, input logic [1:0] k);
      logic [2:0] pos;
      pos = {1'b0, k} & ((3'd1 << s) - 3'd1);
      return TW_W'(pos << (2'd2 - s));
   endfunction
endpackage

// File: rtl/fft8_bf_sched_if.sv
// fft8_bf_sched_if: start/done, RAM and butterfly signals of the scheduler; FFT8_BF_SCHED_CYCLE_CNT_EN adds cycle_cnt
interface fft8_bf_sched_if;
   import fft8_pkg::*;
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              bf_valid_in;
   logic [TW_W-1:0]   tw_idx;
   logic              bf_valid_out;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr_a;
   logic [ADDR_W-1:0] wr_addr_b;
   logic              seq_err;
`ifdef FFT8_BF_SCHED_CYCLE_CNT_EN
   logic [7:0]        cycle_cnt;
`endif

   modport master (
      input  start, bf_valid_out,
`ifdef FFT8_BF_SCHED_CYCLE_CNT_EN
      output cycle_cnt,
`endif
      output busy, done, rd_en, rd_addr_a, rd_addr_b, bf_valid_in, tw_idx,
             wr_en, wr_addr_a, wr_addr_b, seq_err
   );

   modport slave (
      output start, bf_valid_out,
`ifdef FFT8_BF_SCHED_CYCLE_CNT_EN
      input  cycle_cnt,
`endif
      input  busy, done, rd_en, rd_addr_a, rd_addr_b, bf_valid_in, tw_idx,
             wr_en, wr_addr_a, wr_addr_b, seq_err
   );
endinterface

// File: rtl/fft8_tag_pipe.sv
// fft8_tag_pipe: fixed-depth shift register of butterfly tags with synchronous clear
module fft8_tag_pipe
   import fft8_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  bf_tag_t d_i,
   output bf_tag_t q_o,
   output logic    pend_o
);
   bf_tag_t sr_q [DEPTH];

   // shift one stage per cycle, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   // any valid tag still upstream of the output stage
   always_comb begin
      pend_o = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) pend_o = pend_o | sr_q[i].valid;
   end

   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft8_bf_sched.sv
// fft8_bf_sched: 3-stage x 4-butterfly in-place FFT8 scheduler; FFT8_BF_SCHED_CYCLE_CNT_EN adds cycle_cnt
module fft8_bf_sched
   import fft8_pkg::*;
#(
   parameter int L_MUL  = 2,
   parameter int L_ADD  = 2,
   parameter int RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fft8_bf_sched_if.master        bus
);
   localparam int BF_LAT = L_MUL + 2 * L_ADD;

   sched_state_t    state_q, state_d;
   logic [1:0]      s_q, s_d, k_q, k_d;
   logic            rd_en, drained, seq_err_q;
   bf_tag_t         rd_tag, rd_q, bf_q;
   logic            rd_pend, bf_pend;
   logic [TW_W-1:0] tw_q [RD_LAT];

   assign rd_en   = state_q == ISSUE;
   assign rd_tag  = rd_en ? bf_addr(s_q, k_q) : '0;
   // the stage is finished once only the final write-back tag remains in flight
   assign drained = !rd_pend && !rd_q.valid && !bf_pend;

   // next-state logic for the issue / drain sequencing
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE:  if (bus.start) begin
                   state_d = ISSUE;
                   s_d     = 2'd0;
                   k_d     = 2'd0;
                end
         ISSUE: begin
                   k_d     = k_q + 2'd1;
                   state_d = (k_q == 2'd3) ? DRAIN : ISSUE;
                end
         DRAIN: if (drained) begin
                   state_d = (s_q == 2'd2) ? DONE : ISSUE;
                   s_d     = (s_q == 2'd2) ? s_q : s_q + 2'd1;
                   k_d     = 2'd0;
                end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM, counters and sticky tracking error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         s_q       <= '0;
         k_q       <= '0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         k_q       <= k_d;
         seq_err_q <= seq_err_q | (bus.bf_valid_out != bf_q.valid);
      end
   end

   // twiddle index travels with the read-latency tag stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) tw_q[i] <= '0;
      end else begin
         tw_q[0] <= rd_en ? bf_tw(s_q, k_q) : '0;
         for (int i = 1; i < RD_LAT; i++) tw_q[i] <= tw_q[i-1];
      end
   end

   fft8_tag_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (rd_tag),
      .q_o    (rd_q),
      .pend_o (rd_pend)
   );

   fft8_tag_pipe #(.DEPTH(BF_LAT)) u_bf_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (rd_q),
      .q_o    (bf_q),
      .pend_o (bf_pend)
   );

`ifdef FFT8_BF_SCHED_CYCLE_CNT_EN
   logic [7:0] cnt_q;

   // busy-cycle count of the current or most recent transform
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else if (state_q == IDLE && bus.start) cnt_q <= '0;
      else if (rd_en || state_q == DRAIN) cnt_q <= cnt_q + 8'd1;
   end

   assign bus.cycle_cnt = cnt_q;
`endif

   assign bus.busy        = rd_en || state_q == DRAIN;
   assign bus.done        = state_q == DONE;
   assign bus.rd_en       = rd_en;
   assign bus.rd_addr_a   = rd_tag.addr_a;
   assign bus.rd_addr_b   = rd_tag.addr_b;
   assign bus.bf_valid_in = rd_q.valid;
   assign bus.tw_idx      = tw_q[RD_LAT-1];
   assign bus.wr_en       = bf_q.valid;
   assign bus.wr_addr_a   = bf_q.addr_a;
   assign bus.wr_addr_b   = bf_q.addr_b;
   assign bus.seq_err     = seq_err_q;
endmodule

// File: tb/tb_fft8_bf_sched.sv
// tb_fft8_bf_sched: directed checks of the FFT8 scheduler with an echo butterfly model
module tb_fft8_bf_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic glitch = 1'b0;
   logic [5:0] echo_sr = '0;
   int checks = 0;
   int errors = 0;

   logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
   logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

   fft8_bf_sched_if bus ();

   fft8_bf_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // butterfly stand-in: valid_out is valid_in six cycles later
   always @(posedge clk) echo_sr <= rst_n ? {echo_sr[4:0], bus.bf_valid_in} : 6'd0;
   assign bus.bf_valid_out = echo_sr[5] ^ glitch;

   task automatic chk(input string tag, input int c, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, c, obs, exp);
      end
   endtask

   // butterfly index issued in cycle c (stages start at 1, 12, 23), or -1
   function automatic int idx_at(input int c);
      for (int st = 0; st < 3; st++)
         if (c >= 1 + 11 * st && c <= 4 + 11 * st) return st * 4 + c - 1 - 11 * st;
      return -1;
   endfunction

   task automatic chk_idle(input string tag, input int c);
      chk({tag, "_busy"}, c, bus.busy, 0);
      chk({tag, "_done"}, c, bus.done, 0);
      chk({tag, "_rd_en"}, c, bus.rd_en, 0);
      chk({tag, "_rd_a"}, c, bus.rd_addr_a, 0);
      chk({tag, "_rd_b"}, c, bus.rd_addr_b, 0);
      chk({tag, "_vin"}, c, bus.bf_valid_in, 0);
      chk({tag, "_tw"}, c, bus.tw_idx, 0);
      chk({tag, "_wr_en"}, c, bus.wr_en, 0);
      chk({tag, "_wr_a"}, c, bus.wr_addr_a, 0);
      chk({tag, "_wr_b"}, c, bus.wr_addr_b, 0);
   endtask

   // start in cycle 0; xs: extra start cycle, gl: glitch cycle, ab: reset cycle (0 = none)
   task automatic run(input int xs, input int gl, input int ab);
      int i, j, w;
      logic nrm;
      @(negedge clk);
      bus.start = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         bus.start = (c == xs);
         glitch    = (c == gl);
         rst_n     = !(ab > 0 && c == ab);
         nrm = !(ab > 0 && c > ab);
         i = nrm ? idx_at(c) : -1;
         j = nrm ? idx_at(c - 1) : -1;
         w = nrm ? idx_at(c - 7) : -1;
         if (!nrm) chk_idle("abort", c);
         chk("busy", c, bus.busy, int'(nrm && c <= 33));
         chk("done", c, bus.done, int'(nrm && c == 34));
         chk("rd_en", c, bus.rd_en, int'(i >= 0));
         if (i >= 0) begin
            chk("rd_a", c, bus.rd_addr_a, exp_a[i]);
            chk("rd_b", c, bus.rd_addr_b, exp_b[i]);
         end
         chk("vin", c, bus.bf_valid_in, int'(j >= 0));
         if (j >= 0) chk("tw", c, bus.tw_idx, exp_tw[j]);
         chk("wr_en", c, bus.wr_en, int'(w >= 0));
         if (w >= 0) begin
            chk("wr_a", c, bus.wr_addr_a, exp_a[w]);
            chk("wr_b", c, bus.wr_addr_b, exp_b[w]);
         end
         chk("seq_err", c, bus.seq_err, int'(gl > 0 && c > gl));
      end
`ifdef FFT8_BF_SCHED_CYCLE_CNT_EN
      chk("cycle_cnt", 36, bus.cycle_cnt, ab > 0 ? 0 : 33);
`endif
   endtask

   initial begin
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("reset", 0);
      chk("reset_seq_err", 0, bus.seq_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("idle", 0);
      run(0, 0, 0);
      run(10, 0, 0);
      run(0, 0, 15);
      repeat (3) @(negedge clk);
      chk("post_abort_wr", 0, bus.wr_en, 0);
      chk("post_abort_busy", 0, bus.busy, 0);
      run(0, 0, 0);
      run(0, 5, 0);
      repeat (3) @(negedge clk);
      chk("sticky_seq_err", 0, bus.seq_err, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("cleared_seq_err", 0, bus.seq_err, 0);
      chk_idle("final", 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
